// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counting timer.
package down_counter_timer_pkg;

  localparam int DCT_DEFAULT_WIDTH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dct_state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with valid/ready start and single-cycle done pulse.
// Define DOWN_COUNTER_TIMER_RELOAD_EN for periodic (auto-reload) operation.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DCT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  dct_state_e       r_state;
  dct_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_start_ready;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  logic [WIDTH-1:0] r_reload_q;
  logic [WIDTH-1:0] w_reload_nxt;
`endif

  // abort in IDLE blocks acceptance without otherwise touching state
  assign w_start_ready = (r_state == ST_IDLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
      r_reload_q <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
      r_reload_q <= w_reload_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
    w_reload_nxt = r_reload_q;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start_valid && w_start_ready) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = load_value;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
          w_reload_nxt = load_value;
`endif
        end
      end
      ST_RUN: begin
        // abort takes priority over a terminal count on the same edge
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else if (en) begin
          if (r_count == '0) begin
            w_done_nxt = 1'b1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
            w_count_nxt = r_reload_q;
`else
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign start_ready = w_start_ready;
  assign count       = r_count;
  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counting timer: the countdown counterpart of the free-running up counter. It accepts a start value over a valid/ready handshake, decrements to zero on enabled cycles, then emits a single-cycle `done` pulse. It sits beside the up counters in the timing/sequencing path and supplies one-shot (or, optionally, periodic) delays to control FSMs.

## Interface
- `WIDTH`, default 3: counter and load-value width in bits.
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start_valid`  input  1  request to load `load_value` and begin counting.
- `start_ready`  output  1  block can accept a start.
- `load_value`  input  WIDTH  start count N, sampled on handshake.
- `en`  input  1  count enable; low freezes `count` and the state.
- `abort`  input  1  cancel the run in progress.
- `count`  output  WIDTH  current remaining count.
- `busy`  output  1  high while in RUN.
- `done`  output  1  single-cycle pulse on terminal count.

## Operation
- FSM has two states. IDLE: `start_ready`=1 when `abort`=0. RUN: `busy`=1, `start_ready`=0.
- IDLE→RUN on `start_valid && start_ready`: `count`<=`load_value`. `load_value` is also latched into `reload_q`.
- RUN with `en`=1 and `count`≠0: `count`<=`count`−1.
- RUN with `en`=1 and `count`==0: `done`<=1 for one cycle. Next state is IDLE, or depends on the reload option (see Configuration).
- RUN with `en`=0: hold everything; `done` stays 0.
- `abort`=1 in RUN: next state is IDLE, `count`<=0, no `done`. `abort` beats terminal count on the same edge.
- `abort`=1 in IDLE: forces `start_ready`=0, so no start is accepted. Otherwise no effect.
- `start_valid` while in RUN is ignored; it is not queued.
- Arithmetic is unsigned and modulo 2^WIDTH. The decrement is never applied at 0, so there is no wrap to all-ones.
- `done` is registered and is 0 on every cycle except the terminal cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, `count`=0, `reload_q`=0, `busy`=0, `done`=0, `start_ready`=1.
- Handshake accepted at edge k: `count`=N and `busy`=1 from cycle k+1.
- With `en` held high, `done` is visible N+1 cycles after the accept edge.
- N=0: `done` comes on the first enabled edge after the accept.
- One-shot mode: `busy` drops on the same edge that raises `done`, and `start_ready` rises with it. A new start can be accepted on the very next edge, giving back-to-back runs with no gap cycle.
- Reset asserted mid-run: all outputs return to reset values immediately. No `done` is produced.

## Configuration
- Macro: `DOWN_COUNTER_TIMER_RELOAD_EN`.
- Defined (periodic mode): at terminal count `done` pulses, `count`<=`reload_q`, and the state stays RUN. `done` then repeats every `reload_q`+1 enabled cycles until `abort`.
- Undefined (one-shot mode): the terminal count returns the block to IDLE as described above. `reload_q` is not implemented.

## Structure
- Shared package `down_counter_timer_pkg`:
  - state typedef with IDLE/RUN encodings
  - default-width constant
- No sub-module. A single module holds the FSM, the counter register and the reload register.

## Test plan
- Reset: assert `rst_n`=0 mid-count with `count`=5 → `count`=0, `busy`=0, `done`=0 immediately. `start_ready`=1 after release.
- One-shot: WIDTH=3, load 5, `en`=1 → `count` sequence 5,4,3,2,1,0, `done` 6 cycles after accept, then IDLE. Also load 0 → `done` on the next cycle.
- Enable gating: load 3, drop `en` for 4 cycles at `count`=2 → `count` holds at 2. `done` is delayed by exactly 4 cycles.
- Abort: load 7, assert `abort` when `count`=0 → no `done`, IDLE next cycle. Abort together with `start_valid` in IDLE → `start_ready`=0 and no load.
- Back-to-back, one-shot: hold `start_valid` with load 2 → `done` pulses separated by exactly 4 cycles.
- Reload (macro defined): load 2 with `en`=1 → `done` every 3 cycles and `count` cycling 2,1,0. `abort` stops it with no further `done`.
